// File: rtl/rb_arbiter_pkg.sv
// rb_arbiter_pkg: shared types for the register-bank access arbiter.
//   rb_idx_t     4-bit register index
//   rb_word_t    16-bit register data word
//   rb_sel_t     packed select word {dst, srca, srcb}, 12 bits
//   arb_state_t  arbiter FSM state (ARB_FREE / ARB_LOCK)
//   RB_ARB_NREQ_MAX  largest supported requester count
package rb_arbiter_pkg;

    typedef logic [3:0]  rb_idx_t;
    typedef logic [15:0] rb_word_t;

    typedef struct packed {
        rb_idx_t dst;
        rb_idx_t srca;
        rb_idx_t srcb;
    } rb_sel_t;

    typedef enum logic {
        ARB_FREE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    localparam int RB_ARB_NREQ_MAX = 4;

endpackage

// File: rtl/rb_arbiter_if.sv
// rb_arbiter_if: requester handshake plus register-bank port of rb_arbiter.
//   Requester side : req_in, we_in, lock_in, rs_in, d_in -> gnt_out,
//                    rvalid_out, a_out, b_out
//   Bank side      : rb_rw_out, rb_rs_out, rb_d_out -> rb_a_in, rb_b_in
//   busy_out       : issue stage holds a valid op
// Modports: slave = the arbiter, master = requesters + bank environment.
interface rb_arbiter_if
    import rb_arbiter_pkg::*;
#(
    parameter int NREQ = 2
);
    logic     [NREQ-1:0] req_in;
    logic     [NREQ-1:0] we_in;
    logic     [NREQ-1:0] lock_in;
    rb_sel_t  [NREQ-1:0] rs_in;
    rb_word_t [NREQ-1:0] d_in;
    logic     [NREQ-1:0] gnt_out;
    logic     [NREQ-1:0] rvalid_out;
    rb_word_t            a_out;
    rb_word_t            b_out;
    logic                rb_rw_out;
    rb_sel_t             rb_rs_out;
    rb_word_t            rb_d_out;
    rb_word_t            rb_a_in;
    rb_word_t            rb_b_in;
    logic                busy_out;

    modport slave (
        input  req_in, we_in, lock_in, rs_in, d_in, rb_a_in, rb_b_in,
        output gnt_out, rvalid_out, a_out, b_out,
               rb_rw_out, rb_rs_out, rb_d_out, busy_out
    );

    modport master (
        output req_in, we_in, lock_in, rs_in, d_in, rb_a_in, rb_b_in,
        input  gnt_out, rvalid_out, a_out, b_out,
               rb_rw_out, rb_rs_out, rb_d_out, busy_out
    );
endinterface

// File: rtl/rb_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   in  NREQ  request vector
//   last  in  4     index of the previous winner
//   gnt   out NREQ  one-hot winner: first requesting index after last,
//                   searching upward with wrap; all zero if no request.
module rr_pick
    import rb_arbiter_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  rb_idx_t         last,
    output logic [NREQ-1:0] gnt
);
    logic found;

    // Outer loop walks the priority order (last+1, last+2, ...); the inner
    // loop keeps every bit select constant after unrolling.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && req[j] && (((int'(last) + k) % NREQ) == j)) begin
                    gnt[j] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/rb_arbiter.sv
// rb_arbiter: shares one register-bank port between NREQ requesters.
//   clk  clock
//   rst  asynchronous reset, active-high
//   bus  rb_arbiter_if.slave (requester handshake + bank port)
// Grant is combinational in cycle N; the op is issued on rb_* and its
// response pulse appears in N+1. Read data passes straight through.
// Build option: define RB_ARB_LOCK_EN to honour lock_in (ARB_LOCK state,
// lock counter bounded by MAXLOCK); otherwise pure round-robin.
module rb_arbiter
    import rb_arbiter_pkg::*;
#(
    parameter int NREQ    = 2,  // 2..RB_ARB_NREQ_MAX
    parameter int MAXLOCK = 4
) (
    input  logic         clk,
    input  logic         rst,
    rb_arbiter_if.slave  bus
);
    logic [NREQ-1:0] req_mask;
    logic [NREQ-1:0] pick;
    logic            granted;
    rb_idx_t         win_idx;
    logic            sel_we;
    logic            sel_lock;
    rb_sel_t         sel_rs;
    rb_word_t        sel_d;
    rb_idx_t         last_reg;
    rb_idx_t         last_next;

    logic            iss_valid_reg;
    logic            iss_we_reg;
    logic [NREQ-1:0] iss_src_reg;
    rb_sel_t         rs_reg;
    rb_word_t        d_reg;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req  (req_mask),
        .last (last_reg),
        .gnt  (pick)
    );

    assign granted = |pick;

    // One-hot to index and field mux for the winning requester.
    always_comb begin
        win_idx  = '0;
        sel_we   = 1'b0;
        sel_lock = 1'b0;
        sel_rs   = '0;
        sel_d    = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (pick[k]) begin
                win_idx  = rb_idx_t'(k);
                sel_we   = bus.we_in[k];
                sel_lock = bus.lock_in[k];
                sel_rs   = bus.rs_in[k];
                sel_d    = bus.d_in[k];
            end
        end
    end

`ifdef RB_ARB_LOCK_EN
    localparam int CNT_W = $clog2(MAXLOCK + 1);

    arb_state_t      state_reg;
    rb_idx_t         owner_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [NREQ-1:0] owner_onehot;
    logic            owner_req;
    logic            lock_expired;

    assign owner_onehot = NREQ'(1) << owner_reg;
    assign owner_req    = |(bus.req_in & owner_onehot);
    // The entry grant is cycle 1 of the lock span, so the current cycle is
    // number cnt_reg+1; the span's final cycle is left ungranted.
    assign lock_expired = (state_reg == ARB_LOCK) && ((int'(cnt_reg) + 1) == MAXLOCK);

    always_comb begin
        req_mask = bus.req_in;
        if (state_reg == ARB_LOCK) begin
            req_mask = lock_expired ? '0 : (bus.req_in & owner_onehot);
        end
    end

    always_comb begin
        last_next = last_reg;
        if (granted) begin
            last_next = win_idx;
        end else if (lock_expired) begin
            last_next = owner_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ARB_FREE;
            owner_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ARB_FREE: begin
                    if (granted && sel_lock) begin
                        state_reg <= ARB_LOCK;
                        owner_reg <= win_idx;
                        cnt_reg   <= CNT_W'(1);
                    end
                end
                ARB_LOCK: begin
                    if (lock_expired || !owner_req || (granted && !sel_lock)) begin
                        state_reg <= ARB_FREE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg   <= cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= ARB_FREE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end
`else
    logic lock_unused;

    assign lock_unused = sel_lock;
    assign req_mask    = bus.req_in;
    assign last_next   = granted ? win_idx : last_reg;
`endif

    // Issue stage: accepts every cycle; select word and data hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_reg      <= rb_idx_t'(NREQ - 1);
            iss_valid_reg <= 1'b0;
            iss_we_reg    <= 1'b0;
            iss_src_reg   <= '0;
            rs_reg        <= '0;
            d_reg         <= '0;
        end else begin
            last_reg      <= last_next;
            iss_valid_reg <= granted;
            iss_we_reg    <= granted && sel_we;
            iss_src_reg   <= pick;
            if (granted) begin
                rs_reg <= sel_rs;
                d_reg  <= sel_d;
            end
        end
    end

    assign bus.gnt_out    = pick;
    assign bus.rvalid_out = iss_src_reg;
    assign bus.busy_out   = iss_valid_reg;
    assign bus.rb_rw_out  = iss_we_reg;
    assign bus.rb_rs_out  = rs_reg;
    assign bus.rb_d_out   = d_reg;
    assign bus.a_out      = bus.rb_a_in;
    assign bus.b_out      = bus.rb_b_in;
endmodule

// File: tb/tb_rb_arbiter.sv
// tb_rb_arbiter: directed self-checking bench for rb_arbiter (NREQ=2,
// MAXLOCK=4) with a 16-entry register-bank model on the bank port.
// Expected lock-test grants depend on RB_ARB_LOCK_EN.
module tb_rb_arbiter;
    import rb_arbiter_pkg::*;

    localparam int NREQ = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rb_arbiter_if #(.NREQ(NREQ)) bus ();

    rb_arbiter #(.NREQ(NREQ), .MAXLOCK(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register bank: combinational read, write at the clock edge.
    rb_word_t bank [16];
    assign bus.rb_a_in = bank[bus.rb_rs_out.srca];
    assign bus.rb_b_in = bank[bus.rb_rs_out.srcb];
    always @(posedge clk) begin
        if (bus.rb_rw_out) bank[bus.rb_rs_out.dst] <= bus.rb_d_out;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_all();
        bus.req_in  = '0;
        bus.we_in   = '0;
        bus.lock_in = '0;
        bus.rs_in   = '0;
        bus.d_in    = '0;
    endtask

    task automatic set_op(input int i, input logic we, input logic lk,
                          input logic [11:0] rs, input logic [15:0] d);
        bus.req_in[i]  = 1'b1;
        bus.we_in[i]   = we;
        bus.lock_in[i] = lk;
        bus.rs_in[i]   = rs;
        bus.d_in[i]    = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    logic [1:0]  lock_exp [5];
    logic [1:0]  g_exp;
    logic [1:0]  p_exp;
    logic [15:0] a_exp;
    logic [15:0] b_exp;

    initial begin
        for (int i = 0; i < 16; i++) bank[i] <= 16'h1000 + 16'(i);
`ifdef RB_ARB_LOCK_EN
        lock_exp = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10};
`else
        lock_exp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
`endif
        rst = 1'b1;
        idle_all();

        // 1: reset values, then a single write
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_gnt",    32'(bus.gnt_out),    32'h0);
        check_eq("rst_rvalid", 32'(bus.rvalid_out), 32'h0);
        check_eq("rst_rw",     32'(bus.rb_rw_out),  32'h0);
        check_eq("rst_busy",   32'(bus.busy_out),   32'h0);
        check_eq("rst_rs",     32'(bus.rb_rs_out),  32'h0);
        check_eq("rst_d",      32'(bus.rb_d_out),   32'h0);
        rst = 1'b0;
        set_op(0, 1'b1, 1'b0, 12'h500, 16'hBEEF);
        #1;
        check_eq("t1_gnt", 32'(bus.gnt_out), 32'h1);
        $display("t1 write req0 granted gnt=%b", bus.gnt_out);
        cycle();
        idle_all();
        #1;
        check_eq("t1_rw",     32'(bus.rb_rw_out),  32'h1);
        check_eq("t1_rs",     32'(bus.rb_rs_out),  32'h500);
        check_eq("t1_d",      32'(bus.rb_d_out),   32'hBEEF);
        check_eq("t1_rvalid", 32'(bus.rvalid_out), 32'h1);
        check_eq("t1_gnt0",   32'(bus.gnt_out),    32'h0);

        // 6: idle cycles hold select word and data
        for (int k = 0; k < 5; k++) begin
            cycle();
            #1;
            check_eq("t6_rw",     32'(bus.rb_rw_out),  32'h0);
            check_eq("t6_rvalid", 32'(bus.rvalid_out), 32'h0);
            check_eq("t6_busy",   32'(bus.busy_out),   32'h0);
            check_eq("t6_rs",     32'(bus.rb_rs_out),  32'h500);
            check_eq("t6_d",      32'(bus.rb_d_out),   32'hBEEF);
            $display("t6 idle cycle %0d rs=%h", k, bus.rb_rs_out);
        end

        // 2: both requesters read continuously from reset
        do_reset();
        set_op(0, 1'b0, 1'b0, 12'h012, 16'h0);
        set_op(1, 1'b0, 1'b0, 12'h067, 16'h0);
        for (int k = 0; k < 4; k++) begin
            #1;
            g_exp = (k % 2 == 0) ? 2'b01 : 2'b10;
            check_eq("t2_gnt", 32'(bus.gnt_out), 32'(g_exp));
            if (k > 0) begin
                p_exp = (k % 2 == 0) ? 2'b10 : 2'b01;
                a_exp = (k % 2 == 0) ? 16'h1006 : 16'h1001;
                b_exp = (k % 2 == 0) ? 16'h1007 : 16'h1002;
                check_eq("t2_rvalid", 32'(bus.rvalid_out), 32'(p_exp));
                check_eq("t2_busy",   32'(bus.busy_out),   32'h1);
                check_eq("t2_a",      32'(bus.a_out),      32'(a_exp));
                check_eq("t2_b",      32'(bus.b_out),      32'(b_exp));
            end
            $display("t2 cycle %0d gnt=%b rvalid=%b", k, bus.gnt_out, bus.rvalid_out);
            cycle();
        end
        idle_all();
        #1;
        check_eq("t2_rvalid_last", 32'(bus.rvalid_out), 32'h2);
        check_eq("t2_busy_last",   32'(bus.busy_out),   32'h1);
        check_eq("t2_a_last",      32'(bus.a_out),      32'h1006);

        // 3: write r3 by req1, then read r3/r4 by req0
        cycle();
        set_op(1, 1'b1, 1'b0, 12'h300, 16'h1234);
        #1;
        check_eq("t3_gnt_w", 32'(bus.gnt_out), 32'h2);
        cycle();
        idle_all();
        set_op(0, 1'b0, 1'b0, 12'h034, 16'h0);
        #1;
        check_eq("t3_gnt_r",  32'(bus.gnt_out),    32'h1);
        check_eq("t3_rw",     32'(bus.rb_rw_out),  32'h1);
        check_eq("t3_rvalid", 32'(bus.rvalid_out), 32'h2);
        cycle();
        idle_all();
        #1;
        check_eq("t3_rvalid_r", 32'(bus.rvalid_out), 32'h1);
        check_eq("t3_a",        32'(bus.a_out),      32'h1234);
        check_eq("t3_b",        32'(bus.b_out),      32'h1004);
        check_eq("t3_rw0",      32'(bus.rb_rw_out),  32'h0);
        $display("t3 read after write a=%h b=%h", bus.a_out, bus.b_out);

        // 4: req0 locks while req1 waits
        cycle();
        do_reset();
        set_op(0, 1'b0, 1'b1, 12'h012, 16'h0);
        set_op(1, 1'b0, 1'b0, 12'h067, 16'h0);
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq("t4_gnt", 32'(bus.gnt_out), 32'(lock_exp[k]));
            $display("t4 cycle %0d gnt=%b", k, bus.gnt_out);
            cycle();
        end
        idle_all();

        // 5: reset between write grant and issue drops the write
        cycle();
        set_op(0, 1'b1, 1'b0, 12'h700, 16'hDEAD);
        #1;
        check_eq("t5_gnt", 32'(bus.gnt_out), 32'h1);
        #2;
        rst = 1'b1;
        idle_all();
        @(posedge clk);
        #1;
        check_eq("t5_rw",     32'(bus.rb_rw_out),  32'h0);
        check_eq("t5_rvalid", 32'(bus.rvalid_out), 32'h0);
        check_eq("t5_busy",   32'(bus.busy_out),   32'h0);
        #1;
        rst = 1'b0;
        cycle();
        set_op(0, 1'b0, 1'b0, 12'h077, 16'h0);
        #1;
        check_eq("t5_gnt_r", 32'(bus.gnt_out), 32'h1);
        cycle();
        idle_all();
        #1;
        check_eq("t5_rvalid_r", 32'(bus.rvalid_out), 32'h1);
        check_eq("t5_a",        32'(bus.a_out),      32'h1007);
        check_eq("t5_b",        32'(bus.b_out),      32'h1007);
        $display("t5 read after dropped write a=%h", bus.a_out);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
